unidade_controle_desafio: RTL and testbench
===========================================

// Module: unidade_controle_desafio
// PURPOSE
// Moore FSM that sequences the sequence-memory game datapath (fluxo_dados_desafio). Per round it shows
// addresses 0..sequencia on the LEDs with timed on/off phases. It then collects one move per address and
// compares it, growing the sequence up to 16 until hit, miss or timeout. Sits between top-level buttons and
// the datapath; drives every datapath control input and takes back every datapath status output.
// PARAMETERS
// MODO_RESET  1'b0  value of memoria (ROM bank select) after reset, until the first latch by iniciar
// PORTS
// clock                  in   1  system clock, all state changes on rising edge
// reset                  in   1  synchronous, active-high; forces state inicial
// iniciar                in   1  start/restart request (level, sampled each cycle)
// modo                   in   1  ROM bank for the next game: 0=bank0, 1=bank1
// fimLedsOn, fimLedsOff  in   1  LED on/off phase timers expired
// jogadaIgualMemoria     in   1  registered move == ROM word at current address
// enderecoIgualSequencia in   1  address counter == sequence counter
// tem_jogada             in   1  one-cycle pulse: new move on chaves
// fimS                   in   1  sequence counter at 15 (last round)
// timeout                in   1  sticky timeout flag from datapath (cleared by zeraR)
// zeraE, contaE          out  1  address counter clear / count
// zeraS, contaS          out  1  sequence counter clear / count
// zeraR, registraR       out  1  move register clear / load
// estado_espera          out  1  high in espera (runs timeout counter)
// estado_ledsOn          out  1  high in leds_on
// estado_ledsOff         out  1  high in leds_off
// memoria                out  1  latched ROM bank select
// pronto, acertou, errou out  1  game ended; hit result; miss result (errou also set on timeout)
// db_timeout             out  1  game ended by timeout
// db_estado              out  4  current state code
// BEHAVIOUR
// States/codes: inicial 0, preparacao 1, inicio_exib 2, leds_on 3, leds_off 4, prox_led 5, inicio_jog 6,
//   espera 7, registra 8, comparacao 9, prox_jogada A, prox_seq B, fim_acertou C, fim_errou D, fim_timeout E.
// Transitions (one per clock, evaluated in listed priority):
//   inicial: iniciar -> preparacao, latch memoria<=modo. Otherwise stay.
//   preparacao -> inicio_exib.   inicio_exib -> leds_on.   leds_on: fimLedsOn -> leds_off.
//   leds_off: fimLedsOff & enderecoIgualSequencia -> inicio_jog; fimLedsOff & !enderecoIgualSequencia -> prox_led.
//   prox_led -> leds_on.   inicio_jog -> espera.
//   espera: tem_jogada -> registra; else timeout -> fim_timeout (tem_jogada wins if same cycle).
//   registra -> comparacao.
//   comparacao: !jogadaIgualMemoria -> fim_errou; !enderecoIgualSequencia -> prox_jogada;
//     fimS -> fim_acertou; else -> prox_seq.
//   prox_jogada -> espera.   prox_seq -> inicio_exib.
//   fim_*: iniciar -> preparacao with memoria<=modo (restart); else hold.
// Outputs (Moore, decoded from state only; all 0 unless listed):
//   preparacao: zeraE, zeraS, zeraR.   inicio_exib: zeraE, zeraR.   leds_on: estado_ledsOn.
//   leds_off: estado_ledsOff.   prox_led: contaE.   inicio_jog: zeraE, zeraR.   espera: estado_espera.
//   registra: registraR.   prox_jogada: contaE.   prox_seq: contaS.
//   fim_acertou: pronto, acertou.   fim_errou: pronto, errou.   fim_timeout: pronto, errou, db_timeout.
// Reset: state inicial; all outputs 0, memoria=MODO_RESET, db_estado=0. Reset mid-game: same, next edge.
// Compare occurs in comparacao, one cycle after registraR, so the move register and the sync ROM word are settled.
// Sequence grows 0..15; fimS checked only on full-round hit; no wrap-around past 15.
// memoria is stable for the whole game; changes on modo are ignored outside inicial/fim_*.
// CONFIGURATION
// UC_TIMEOUT_EN defined: espera->fim_timeout path as above.
// UC_TIMEOUT_EN undefined: timeout input ignored; espera leaves only on tem_jogada;
//   fim_timeout unreachable; db_timeout tied 0.
// TESTING
// reset=1 one cycle in leds_on -> next cycle db_estado=0, all control outputs 0, memoria=MODO_RESET.
// modo=1, iniciar pulse -> db_estado 1,2,3; memoria=1; estado_ledsOn held until fimLedsOn.
// Round 0: leds_off, fimLedsOff & enderecoIgualSequencia=1 -> 6 then 7; tem_jogada & igual -> 8,9,B (contaS=1 for 1 cycle).
// Round 1: fimLedsOff, enderecoIgualSequencia=0 -> prox_led, contaE=1 one cycle.
//   Wrong move in comparacao -> fim_errou, pronto=errou=1.
// fimS=1 with full correct last round -> fim_acertou, pronto=acertou=1; iniciar -> preparacao with zeraE=zeraS=zeraR=1.
// In espera, timeout=1 -> fim_timeout (db_timeout=1). timeout & tem_jogada same cycle -> registra.
//   Without UC_TIMEOUT_EN, stays in espera.

Source files
------------

// File: rtl/unidade_controle_desafio.sv
// Moore control FSM for the sequence-memory game (fluxo_dados_desafio datapath).
// Optional macro UC_TIMEOUT_EN enables the espera -> fim_timeout exit on the datapath timeout flag.
module unidade_controle_desafio #(
    parameter logic MODO_RESET = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       modo,
    input  logic       fimLedsOn,
    input  logic       fimLedsOff,
    input  logic       jogadaIgualMemoria,
    input  logic       enderecoIgualSequencia,
    input  logic       tem_jogada,
    input  logic       fimS,
    input  logic       timeout,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraS,
    output logic       contaS,
    output logic       zeraR,
    output logic       registraR,
    output logic       estado_espera,
    output logic       estado_ledsOn,
    output logic       estado_ledsOff,
    output logic       memoria,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        INICIO_EXIB = 4'h2,
        LEDS_ON     = 4'h3,
        LEDS_OFF    = 4'h4,
        PROX_LED    = 4'h5,
        INICIO_JOG  = 4'h6,
        ESPERA      = 4'h7,
        REGISTRA    = 4'h8,
        COMPARACAO  = 4'h9,
        PROX_JOGADA = 4'hA,
        PROX_SEQ    = 4'hB,
        FIM_ACERTOU = 4'hC,
        FIM_ERROU   = 4'hD,
        FIM_TIMEOUT = 4'hE
    } state_t;

    typedef struct packed {
        logic zera_e;
        logic conta_e;
        logic zera_s;
        logic conta_s;
        logic zera_r;
        logic registra_r;
        logic espera;
        logic leds_on;
        logic leds_off;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   memoria_q, memoria_d;

`ifndef UC_TIMEOUT_EN
    logic unused_timeout;
    assign unused_timeout = timeout;
`endif

    always_comb begin
        state_d   = state_q;
        memoria_d = memoria_q;
        case (state_q)
            INICIAL, FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
                if (iniciar) begin
                    state_d   = PREPARACAO;
                    memoria_d = modo;
                end
            end
            PREPARACAO:  state_d = INICIO_EXIB;
            INICIO_EXIB: state_d = LEDS_ON;
            LEDS_ON:     if (fimLedsOn) state_d = LEDS_OFF;
            LEDS_OFF: begin
                if (fimLedsOff)
                    state_d = enderecoIgualSequencia ? INICIO_JOG : PROX_LED;
            end
            PROX_LED:    state_d = LEDS_ON;
            INICIO_JOG:  state_d = ESPERA;
            ESPERA: begin
                // A move arriving in the same cycle as the timeout still counts.
                if (tem_jogada) state_d = REGISTRA;
`ifdef UC_TIMEOUT_EN
                else if (timeout) state_d = FIM_TIMEOUT;
`endif
            end
            REGISTRA:    state_d = COMPARACAO;
            COMPARACAO: begin
                if (!jogadaIgualMemoria)          state_d = FIM_ERROU;
                else if (!enderecoIgualSequencia) state_d = PROX_JOGADA;
                else if (fimS)                    state_d = FIM_ACERTOU;
                else                              state_d = PROX_SEQ;
            end
            PROX_JOGADA: state_d = ESPERA;
            PROX_SEQ:    state_d = INICIO_EXIB;
            default:     state_d = INICIAL;
        endcase
    end

    // Outputs are decoded from the next state so the registered copy always matches state_q.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            PREPARACAO:  begin ctrl_d.zera_e = 1'b1; ctrl_d.zera_s = 1'b1; ctrl_d.zera_r = 1'b1; end
            INICIO_EXIB: begin ctrl_d.zera_e = 1'b1; ctrl_d.zera_r = 1'b1; end
            LEDS_ON:     ctrl_d.leds_on    = 1'b1;
            LEDS_OFF:    ctrl_d.leds_off   = 1'b1;
            PROX_LED:    ctrl_d.conta_e    = 1'b1;
            INICIO_JOG:  begin ctrl_d.zera_e = 1'b1; ctrl_d.zera_r = 1'b1; end
            ESPERA:      ctrl_d.espera     = 1'b1;
            REGISTRA:    ctrl_d.registra_r = 1'b1;
            PROX_JOGADA: ctrl_d.conta_e    = 1'b1;
            PROX_SEQ:    ctrl_d.conta_s    = 1'b1;
            FIM_ACERTOU: begin ctrl_d.pronto = 1'b1; ctrl_d.acertou = 1'b1; end
            FIM_ERROU:   begin ctrl_d.pronto = 1'b1; ctrl_d.errou = 1'b1; end
            FIM_TIMEOUT: begin
                ctrl_d.pronto = 1'b1;
                ctrl_d.errou  = 1'b1;
`ifdef UC_TIMEOUT_EN
                ctrl_d.timeout = 1'b1;
`endif
            end
            default:     ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= INICIAL;
            ctrl_q    <= '0;
            memoria_q <= MODO_RESET;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            memoria_q <= memoria_d;
        end
    end

    assign zeraE          = ctrl_q.zera_e;
    assign contaE         = ctrl_q.conta_e;
    assign zeraS          = ctrl_q.zera_s;
    assign contaS         = ctrl_q.conta_s;
    assign zeraR          = ctrl_q.zera_r;
    assign registraR      = ctrl_q.registra_r;
    assign estado_espera  = ctrl_q.espera;
    assign estado_ledsOn  = ctrl_q.leds_on;
    assign estado_ledsOff = ctrl_q.leds_off;
    assign pronto         = ctrl_q.pronto;
    assign acertou        = ctrl_q.acertou;
    assign errou          = ctrl_q.errou;
    assign db_timeout     = ctrl_q.timeout;
    assign memoria        = memoria_q;
    assign db_estado      = state_q;

endmodule

// File: tb/tb_unidade_controle_desafio.sv
// Directed bench for unidade_controle_desafio: walks full games and checks state code plus every output.
module tb_unidade_controle_desafio;

    logic       clock = 1'b0;
    logic       reset, iniciar, modo, fimLedsOn, fimLedsOff;
    logic       jogadaIgualMemoria, enderecoIgualSequencia, tem_jogada, fimS, timeout;
    logic       zeraE, contaE, zeraS, contaS, zeraR, registraR;
    logic       estado_espera, estado_ledsOn, estado_ledsOff, memoria;
    logic       pronto, acertou, errou, db_timeout;
    logic [3:0] db_estado;

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_mem;

    always #5 clock = ~clock;

    unidade_controle_desafio dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo),
        .fimLedsOn(fimLedsOn), .fimLedsOff(fimLedsOff),
        .jogadaIgualMemoria(jogadaIgualMemoria),
        .enderecoIgualSequencia(enderecoIgualSequencia),
        .tem_jogada(tem_jogada), .fimS(fimS), .timeout(timeout),
        .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS),
        .zeraR(zeraR), .registraR(registraR), .estado_espera(estado_espera),
        .estado_ledsOn(estado_ledsOn), .estado_ledsOff(estado_ledsOff),
        .memoria(memoria), .pronto(pronto), .acertou(acertou), .errou(errou),
        .db_timeout(db_timeout), .db_estado(db_estado)
    );

    // Bit order: zeraE contaE zeraS contaS zeraR registraR espera ledsOn ledsOff memoria pronto acertou errou db_timeout
    function automatic logic [13:0] exp_out(input logic [3:0] st, input logic mem);
        logic [13:0] v;
        case (st)
            4'h1:    v = 14'b10101000000000;
            4'h2:    v = 14'b10001000000000;
            4'h3:    v = 14'b00000001000000;
            4'h4:    v = 14'b00000000100000;
            4'h5:    v = 14'b01000000000000;
            4'h6:    v = 14'b10001000000000;
            4'h7:    v = 14'b00000010000000;
            4'h8:    v = 14'b00000100000000;
            4'hA:    v = 14'b01000000000000;
            4'hB:    v = 14'b00010000000000;
            4'hC:    v = 14'b00000000001100;
            4'hD:    v = 14'b00000000001010;
            4'hE:    v = 14'b00000000001011;
            default: v = 14'b0;
        endcase
        v[4] = mem;
        return v;
    endfunction

    task automatic step(input string tag, input logic [3:0] exp_st);
        logic [13:0] obs;
        logic [13:0] want;
        @(posedge clock);
        #1;
        obs  = {zeraE, contaE, zeraS, contaS, zeraR, registraR, estado_espera,
                estado_ledsOn, estado_ledsOff, memoria, pronto, acertou, errou, db_timeout};
        want = exp_out(exp_st, exp_mem);
        n_vec++;
        assert (db_estado === exp_st) else begin
            n_err++;
            $error("FAIL %s state: got %h expected %h", tag, db_estado, exp_st);
        end
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s outputs: got %b expected %b", tag, obs, want);
        end
        $display("step %-12s state=%h outs=%b", tag, db_estado, obs);
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; modo = 1'b0; fimLedsOn = 1'b0; fimLedsOff = 1'b0;
        jogadaIgualMemoria = 1'b0; enderecoIgualSequencia = 1'b0; tem_jogada = 1'b0;
        fimS = 1'b0; timeout = 1'b0; exp_mem = 1'b0;
        step("reset", 4'h0);
        reset = 1'b0;
        step("idle", 4'h0);

        // Start, then reset from inside leds_on
        modo = 1'b1; iniciar = 1'b1; exp_mem = 1'b1;
        step("start1", 4'h1);
        iniciar = 1'b0; modo = 1'b0;
        step("exib", 4'h2);
        step("ledson", 4'h3);
        reset = 1'b1; exp_mem = 1'b0;
        step("midreset", 4'h0);
        reset = 1'b0;

        // Round 0 with bank 1
        modo = 1'b1; iniciar = 1'b1; exp_mem = 1'b1;
        step("start2", 4'h1);
        iniciar = 1'b0; modo = 1'b0;
        step("r0_exib", 4'h2);
        step("r0_on", 4'h3);
        step("r0_onhold", 4'h3);
        fimLedsOn = 1'b1;
        step("r0_off", 4'h4);
        fimLedsOn = 1'b0; fimLedsOff = 1'b1; enderecoIgualSequencia = 1'b1;
        step("r0_injog", 4'h6);
        fimLedsOff = 1'b0;
        step("r0_espera", 4'h7);
        step("r0_wait", 4'h7);
        modo = 1'b0; iniciar = 1'b1;
        step("r0_ignini", 4'h7);
        iniciar = 1'b0; tem_jogada = 1'b1;
        step("r0_reg", 4'h8);
        tem_jogada = 1'b0; jogadaIgualMemoria = 1'b1;
        step("r0_cmp", 4'h9);
        step("r0_proxseq", 4'hB);

        // Round 1: two LEDs, two moves, second move wrong
        step("r1_exib", 4'h2);
        step("r1_on0", 4'h3);
        fimLedsOn = 1'b1;
        step("r1_off0", 4'h4);
        fimLedsOn = 1'b0; fimLedsOff = 1'b1; enderecoIgualSequencia = 1'b0;
        step("r1_proxled", 4'h5);
        fimLedsOff = 1'b0;
        step("r1_on1", 4'h3);
        fimLedsOn = 1'b1;
        step("r1_off1", 4'h4);
        fimLedsOn = 1'b0; fimLedsOff = 1'b1; enderecoIgualSequencia = 1'b1;
        step("r1_injog", 4'h6);
        fimLedsOff = 1'b0;
        step("r1_espera", 4'h7);
        tem_jogada = 1'b1;
        step("r1_reg0", 4'h8);
        tem_jogada = 1'b0; enderecoIgualSequencia = 1'b0;
        step("r1_cmp0", 4'h9);
        step("r1_proxjog", 4'hA);
        step("r1_espera1", 4'h7);
        tem_jogada = 1'b1; timeout = 1'b1;
        step("r1_jogwins", 4'h8);
        tem_jogada = 1'b0; timeout = 1'b0; jogadaIgualMemoria = 1'b0;
        step("r1_cmp1", 4'h9);
        step("r1_errou", 4'hD);
        step("r1_hold", 4'hD);

        // Restart from fim_errou with bank 0; last-round hit
        iniciar = 1'b1; modo = 1'b0; exp_mem = 1'b0;
        step("restart", 4'h1);
        iniciar = 1'b0; modo = 1'b1;
        step("g2_exib", 4'h2);
        step("g2_on", 4'h3);
        fimLedsOn = 1'b1;
        step("g2_off", 4'h4);
        fimLedsOn = 1'b0; fimLedsOff = 1'b1; enderecoIgualSequencia = 1'b1;
        step("g2_injog", 4'h6);
        fimLedsOff = 1'b0;
        step("g2_espera", 4'h7);
        tem_jogada = 1'b1;
        step("g2_reg", 4'h8);
        tem_jogada = 1'b0; jogadaIgualMemoria = 1'b1; fimS = 1'b1;
        step("g2_cmp", 4'h9);
        step("g2_acertou", 4'hC);
        fimS = 1'b0;
        step("g2_hold", 4'hC);

        // Restart from fim_acertou with bank 1; timeout in espera
        iniciar = 1'b1; modo = 1'b1; exp_mem = 1'b1;
        step("restart2", 4'h1);
        iniciar = 1'b0; modo = 1'b0;
        step("g3_exib", 4'h2);
        step("g3_on", 4'h3);
        fimLedsOn = 1'b1;
        step("g3_off", 4'h4);
        fimLedsOn = 1'b0; fimLedsOff = 1'b1;
        step("g3_injog", 4'h6);
        fimLedsOff = 1'b0;
        step("g3_espera", 4'h7);
        timeout = 1'b1;
`ifdef UC_TIMEOUT_EN
        step("g3_timeout", 4'hE);
        timeout = 1'b0;
        step("g3_tohold", 4'hE);
        iniciar = 1'b1; modo = 1'b0; exp_mem = 1'b0;
        step("restart3", 4'h1);
`else
        step("g3_notimeout", 4'h7);
        step("g3_stillwait", 4'h7);
        timeout = 1'b0; tem_jogada = 1'b1;
        step("g3_reg", 4'h8);
`endif
        iniciar = 1'b0; tem_jogada = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
